// File: rtl/i3c_globals_pkg.sv
// Shared types and constants for the I3C SDR target.
package i3c_globals_pkg;

  typedef enum logic [2:0] {IDLE, ADDR, ACK, WR, RD, IGNORE} i3c_tgt_state_e;

  localparam logic [6:0] I3C_BCAST_ADDR = 7'h7E;

  // T-bit value that makes the 9-bit word {data, T} odd parity.
  function automatic logic odd_parity_t(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/i3c_bus_cond_det.sv
// Synchronizes SCL/SDA and decodes START/Sr, STOP and SCL edges.
module i3c_bus_cond_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_start,
  output logic o_stop,
  output logic o_scl_rise,
  output logic o_scl_fall
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;
  logic                   w_scl;
  logic                   w_sda;

  // Reset to the idle-bus level so releasing reset never fakes an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign o_sda      = w_sda;
  assign o_start    = r_scl_prev & w_scl & r_sda_prev & ~w_sda;
  assign o_stop     = r_scl_prev & w_scl & ~r_sda_prev & w_sda;
  assign o_scl_rise = ~r_scl_prev & w_scl;
  assign o_scl_fall = r_scl_prev & ~w_scl;

endmodule

// File: rtl/i3c_sdr_target.sv
// I3C SDR bus target: header decode/ACK, parity-checked writes, T-bit terminated reads.
module i3c_sdr_target
  import i3c_globals_pkg::*;
#(
  parameter logic [6:0] TGT_ADDR    = 7'h2A,
  parameter bit         RESP_BCAST  = 1'b1,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       sda_oen,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  output logic       wr_perr,
  input  logic [7:0] rd_data,
  input  logic       rd_valid,
  output logic       rd_ready,
  output logic       busy,
  output logic       xfer_done
);

  i3c_tgt_state_e r_state;
  logic [3:0]     r_bit_cnt;
  logic [7:0]     r_shift;
  logic           r_rnw;
  logic           r_bcast;
  logic           r_ack_on;
  logic           r_rdv;
  logic           r_t_final;
  logic           r_addressed;

  logic w_sda, w_start, w_stop, w_scl_rise, w_scl_fall;
  logic w_hdr_self, w_hdr_bcast, w_hdr_match;

  i3c_bus_cond_det #(.SYNC_STAGES(SYNC_STAGES)) u_cond (
    .clock      (clock),
    .reset      (reset),
    .i_scl      (scl_in),
    .i_sda      (sda_in),
    .o_sda      (w_sda),
    .o_start    (w_start),
    .o_stop     (w_stop),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall)
  );

  // Header is judged on the 8th rise: r_shift holds the 7 address bits, w_sda is RnW.
  assign w_hdr_self  = (r_shift[6:0] == TGT_ADDR);
  assign w_hdr_bcast = (r_shift[6:0] == I3C_BCAST_ADDR) && !w_sda && RESP_BCAST;
  assign w_hdr_match = w_hdr_self || w_hdr_bcast;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bit_cnt   <= 4'd0;
      r_shift     <= 8'h00;
      r_rnw       <= 1'b0;
      r_bcast     <= 1'b0;
      r_ack_on    <= 1'b0;
      r_rdv       <= 1'b0;
      r_t_final   <= 1'b0;
      r_addressed <= 1'b0;
      sda_out     <= 1'b1;
      sda_oen     <= 1'b1;
      wr_data     <= 8'h00;
      wr_valid    <= 1'b0;
      wr_perr     <= 1'b0;
      rd_ready    <= 1'b0;
      busy        <= 1'b0;
      xfer_done   <= 1'b0;
    end else begin
      wr_valid  <= 1'b0;
      wr_perr   <= 1'b0;
      rd_ready  <= 1'b0;
      xfer_done <= 1'b0;
      if (w_start) begin
        r_state   <= ADDR;
        r_bit_cnt <= 4'd0;
        r_ack_on  <= 1'b0;
        r_t_final <= 1'b0;
        sda_oen   <= 1'b1;
        sda_out   <= 1'b1;
        busy      <= 1'b1;
        // A repeated START keeps the addressed flag of the ongoing frame.
        if (!busy) r_addressed <= 1'b0;
      end else if (w_stop) begin
        r_state     <= IDLE;
        sda_oen     <= 1'b1;
        sda_out     <= 1'b1;
        busy        <= 1'b0;
        xfer_done   <= r_addressed;
        r_addressed <= 1'b0;
      end else begin
        case (r_state)
          IDLE: ;
          ADDR: if (w_scl_rise) begin
            r_shift <= {r_shift[6:0], w_sda};
            if (r_bit_cnt == 4'd7) begin
              r_bit_cnt <= 4'd0;
              r_rnw     <= w_sda;
              r_bcast   <= w_hdr_bcast;
              r_state   <= w_hdr_match ? ACK : IGNORE;
              if (w_hdr_match) r_addressed <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
          ACK: if (w_scl_fall) begin
            if (!r_ack_on) begin
              r_ack_on <= 1'b1;
              sda_out  <= 1'b0;
              sda_oen  <= 1'b0;
            end else begin
              r_ack_on  <= 1'b0;
              r_bit_cnt <= 4'd0;
              if (r_bcast || !r_rnw) begin
                sda_oen <= 1'b1;
                sda_out <= 1'b1;
                r_state <= r_bcast ? IGNORE : WR;
              end else begin
                // The fall ending ACK is also the first data slot of a read.
                r_state <= RD;
                sda_oen <= 1'b0;
                if (rd_valid) begin
                  r_shift  <= rd_data;
                  sda_out  <= rd_data[7];
                  rd_ready <= 1'b1;
                end else begin
                  sda_out   <= 1'b0;
                  r_t_final <= 1'b1;
                end
              end
            end
          end
          WR: if (w_scl_rise) begin
            if (r_bit_cnt == 4'd8) begin
              r_bit_cnt <= 4'd0;
              if (w_sda == odd_parity_t(r_shift)) begin
                wr_data  <= r_shift;
                wr_valid <= 1'b1;
              end else begin
                wr_perr <= 1'b1;
                r_state <= IGNORE;
              end
            end else begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
          RD: begin
            // r_bit_cnt is the slot currently on the bus: 0..7 data, 8 = T-bit.
            if (w_scl_rise && r_bit_cnt == 4'd7) r_rdv <= rd_valid;
            if (w_scl_fall) begin
              if (r_t_final) begin
                sda_oen   <= 1'b1;
                sda_out   <= 1'b1;
                r_t_final <= 1'b0;
                r_state   <= IGNORE;
              end else if (r_bit_cnt == 4'd7) begin
                sda_out   <= r_rdv;
                r_t_final <= ~r_rdv;
                r_bit_cnt <= 4'd8;
              end else if (r_bit_cnt == 4'd8) begin
                r_shift   <= rd_data;
                sda_out   <= rd_data[7];
                rd_ready  <= 1'b1;
                r_bit_cnt <= 4'd0;
              end else begin
                r_shift   <= {r_shift[6:0], 1'b0};
                sda_out   <= r_shift[6];
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          IGNORE: begin
            sda_oen <= 1'b1;
            sda_out <= 1'b1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i3c_sdr_target.sv
// Randomized bench for i3c_sdr_target: a bus controller drives frames, a transaction model predicts responses.
module tb_i3c_sdr_target;

  logic       clock    = 1'b0;
  logic       reset    = 1'b1;
  logic       scl_drv  = 1'b1;
  logic       sda_drv  = 1'b1;
  logic [7:0] rd_data  = 8'h00;
  logic       rd_valid = 1'b0;
  logic       sda_out, sda_oen, wr_valid, wr_perr, rd_ready, busy, xfer_done;
  logic [7:0] wr_data;
  wire        sda_bus = sda_drv & (sda_oen | sda_out);

  always #5 clock = ~clock;

  i3c_sdr_target #(.TGT_ADDR(7'h2A), .RESP_BCAST(1'b1), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .scl_in(scl_drv), .sda_in(sda_bus),
    .sda_out(sda_out), .sda_oen(sda_oen), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_perr(wr_perr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .xfer_done(xfer_done)
  );

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, busy_chg = 0;
  logic exp_busy = 1'b0;
  bit   mon_en = 1'b0;
  bit   tr_addr = 1'b0;
  logic [7:0] got_wr[$], exp_wr[$];
  int got_perr = 0, got_rdy = 0, got_done = 0;
  int exp_perr = 0, exp_rdy = 0, exp_done = 0;
  logic [7:0] last_wr = 8'h00;
  logic [7:0] tx_data[4];
  logic       tx_t[4];
  logic [7:0] rx_bytes[4];
  logic       rx_t[4];
  logic       rx_ack;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Single compare process: pulse capture plus per-cycle busy check against the model.
  always @(negedge clock) begin
    cyc = cyc + 1;
    if (mon_en && !reset) begin
      if (wr_valid) begin got_wr.push_back(wr_data); last_wr = wr_data; end
      if (wr_perr) got_perr++;
      if (rd_ready) got_rdy++;
      if (xfer_done) got_done++;
      if (wr_valid || wr_perr) check("valid_perr_excl", 32'(wr_valid & wr_perr), 32'd0);
      if (cyc - busy_chg > 6) check("busy", 32'(busy), 32'(exp_busy));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic compare_totals();
    check("wr_count", 32'(got_wr.size()), 32'(exp_wr.size()));
    while (got_wr.size() > 0 && exp_wr.size() > 0)
      check("wr_data", 32'(got_wr.pop_front()), 32'(exp_wr.pop_front()));
    got_wr.delete();
    exp_wr.delete();
    check("perr_total", 32'(got_perr), 32'(exp_perr));
    check("rdy_total", 32'(got_rdy), 32'(exp_rdy));
    check("done_total", 32'(got_done), 32'(exp_done));
  endtask

  task automatic bus_start();
    if (scl_drv) begin
      sda_drv = 1'b0; exp_busy = 1'b1; busy_chg = cyc;
      tick(8); scl_drv = 1'b0;
    end else begin
      sda_drv = 1'b1; tick(4); scl_drv = 1'b1; tick(8);
      sda_drv = 1'b0; exp_busy = 1'b1; busy_chg = cyc;
      tick(8); scl_drv = 1'b0;
    end
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; tick(4); scl_drv = 1'b1; tick(8);
    sda_drv = 1'b1; exp_busy = 1'b0; busy_chg = cyc;
    if (tr_addr) exp_done++;
    tr_addr = 1'b0;
    tick(10);
    compare_totals();
  endtask

  // One SCL period starting and ending with SCL low; returns the bus level at SCL high.
  task automatic clock_bit(input logic b, output logic s);
    tick(4); sda_drv = b; tick(4); scl_drv = 1'b1; tick(3);
    s = sda_bus; tick(5); scl_drv = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(v[i], s);
      check("no_tgt_drive", 32'(s), 32'(v[i]));
    end
  endtask

  task automatic xfer_write(input logic [6:0] addr, input int nb, input bit do_stop);
    logic s;
    logic ack_exp;
    bit   accept;
    ack_exp = (addr == 7'h2A) || (addr == 7'h7E);
    bus_start();
    send_byte({addr, 1'b0});
    clock_bit(1'b1, s);
    rx_ack = s;
    check("wr_hdr_ack", 32'(s), 32'(!ack_exp));
    if (ack_exp) tr_addr = 1'b1;
    accept = ack_exp && (addr != 7'h7E);
    for (int k = 0; k < nb; k++) begin
      send_byte(tx_data[k]);
      clock_bit(tx_t[k], s);
      if (accept) begin
        if (tx_t[k] == ($countones(tx_data[k]) % 2 == 0)) exp_wr.push_back(tx_data[k]);
        else begin exp_perr++; accept = 1'b0; end
      end
    end
    if (do_stop) bus_stop();
  endtask

  task automatic xfer_read(input logic [6:0] addr, input int nb);
    logic s;
    logic ack_exp;
    logic [7:0] b;
    ack_exp = (addr == 7'h2A);
    rd_valid = (nb > 0);
    rd_data = tx_data[0];
    bus_start();
    send_byte({addr, 1'b1});
    clock_bit(1'b1, s);
    rx_ack = s;
    check("rd_hdr_ack", 32'(s), 32'(!ack_exp));
    if (ack_exp) begin
      tr_addr = 1'b1;
      if (nb == 0) begin
        clock_bit(1'b1, s);
        rx_t[0] = s;
        check("rd_empty_t", 32'(s), 32'd0);
      end
      for (int k = 0; k < nb; k++) begin
        b = 8'h00;
        for (int i = 7; i >= 0; i--) begin
          clock_bit(1'b1, s);
          b[i] = s;
          if (i == 7) begin
            rd_valid = (k < nb - 1);
            if (k + 1 < nb) rd_data = tx_data[k+1];
          end
        end
        rx_bytes[k] = b;
        check("rd_byte", 32'(b), 32'(tx_data[k]));
        clock_bit(1'b1, s);
        rx_t[k] = s;
        check("rd_t", 32'(s), 32'(k < nb - 1));
      end
      exp_rdy += nb;
    end
    rd_valid = 1'b0;
    bus_stop();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic s;
    logic [7:0] v;
    int d0, p0, nb;
    logic [6:0] a;

    // Reset state
    tick(4);
    check("rst_oen", 32'(sda_oen), 32'd1);
    check("rst_out", 32'(sda_out), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_pulses", 32'({wr_valid, wr_perr, rd_ready, xfer_done}), 32'd0);
    reset = 1'b0;
    tick(5);
    busy_chg = cyc;
    mon_en = 1'b1;

    // Write A5 with T=1
    tx_data[0] = 8'hA5; tx_t[0] = 1'b1;
    xfer_write(7'h2A, 1, 1'b1);
    check("t1_ack_lit", 32'(rx_ack), 32'd0);
    check("t1_wr_lit", 32'(last_wr), 32'hA5);
    check("t1_done_lit", 32'(got_done), 32'd1);

    // Read 3C twice, second byte terminated with T=0
    tx_data[0] = 8'h3C; tx_data[1] = 8'h3C;
    xfer_read(7'h2A, 2);
    check("t2_b0_lit", 32'(rx_bytes[0]), 32'b0011_1100);
    check("t2_t0_lit", 32'(rx_t[0]), 32'd1);
    check("t2_b1_lit", 32'(rx_bytes[1]), 32'h3C);
    check("t2_t1_lit", 32'(rx_t[1]), 32'd0);
    check("t2_rdy_lit", 32'(got_rdy), 32'd2);

    // Foreign address: no ACK, busy until STOP, no xfer_done
    d0 = got_done;
    tx_data[0] = 8'hA5; tx_t[0] = 1'b1;
    xfer_write(7'h11, 1, 1'b0);
    check("t3_nack_lit", 32'(rx_ack), 32'd1);
    check("t3_busy_lit", 32'(busy), 32'd1);
    bus_stop();
    check("t3_no_done", 32'(got_done), 32'(d0));

    // Bad parity on 8'h01, later byte ignored, Sr recovers
    p0 = got_perr;
    tx_data[0] = 8'h01; tx_t[0] = 1'b1;
    tx_data[1] = 8'h3C; tx_t[1] = 1'b1;
    xfer_write(7'h2A, 2, 1'b0);
    check("t4_perr_lit", 32'(got_perr), 32'(p0 + 1));
    check("t4_no_wr", 32'(got_wr.size()), 32'd0);
    tx_data[0] = 8'h5A; tx_t[0] = 1'b1;
    xfer_write(7'h2A, 1, 1'b1);
    check("t4_recover_lit", 32'(last_wr), 32'h5A);

    // Sr after 4 data bits, then broadcast write: ACKed, data ignored
    bus_start();
    send_byte({7'h2A, 1'b0});
    clock_bit(1'b1, s);
    check("t5_ack", 32'(s), 32'd0);
    tr_addr = 1'b1;
    v = 8'hC3;
    for (int i = 7; i >= 4; i--) clock_bit(v[i], s);
    bus_start();
    send_byte({7'h7E, 1'b0});
    clock_bit(1'b1, s);
    check("t5_bcast_ack", 32'(s), 32'd0);
    send_byte(8'hA5);
    clock_bit(1'b1, s);
    bus_stop();

    // Reset while ACK is driven low
    bus_start();
    send_byte({7'h2A, 1'b0});
    tick(7);
    check("t6_ack_driven", 32'(sda_oen), 32'd0);
    reset = 1'b1;
    #1;
    check("t6_rst_oen", 32'(sda_oen), 32'd1);
    check("t6_rst_out", 32'(sda_out), 32'd1);
    check("t6_rst_busy", 32'(busy), 32'd0);
    exp_busy = 1'b0; busy_chg = cyc; tr_addr = 1'b0;
    tick(1);
    sda_drv = 1'b1; scl_drv = 1'b1;
    tick(4);
    reset = 1'b0;
    tick(6);
    tx_data[0] = 8'h81; tx_t[0] = 1'b1;
    xfer_write(7'h2A, 1, 1'b1);
    check("t6_after_rst_lit", 32'(last_wr), 32'h81);

    // Randomized frames
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = 7'h2A;
        2:       a = 7'h7E;
        default: a = 7'($urandom_range(0, 127));
      endcase
      for (int k = 0; k < 4; k++) begin
        tx_data[k] = 8'($urandom_range(0, 255));
        tx_t[k] = ($countones(tx_data[k]) % 2 == 0) ^ ($urandom_range(0, 4) == 0);
      end
      if ($urandom_range(0, 1) == 0) begin
        nb = $urandom_range(1, 3);
        xfer_write(a, nb, 1'b1);
      end else begin
        nb = $urandom_range(0, 3);
        xfer_read(a, nb);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
